// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states and frame constants.
package fifo_uart_tx_pkg;

   localparam int DATA_W_DEF      = 8;
   localparam int FRAME_DATA_BITS = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

endpackage

// File: rtl/fifo_uart_tx_uart_baud_counter.sv
// Bit-period counter: tick is high on the last cycle of each serial bit.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clear || (r_count == LAST)) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign tick = (r_count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO and sends each byte as UART 8N1, LSB first.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_read_en,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

   state_t                     r_state;
   state_t                     w_next;
   logic [FRAME_DATA_BITS-1:0] r_shift;
   logic [2:0]                 r_bit_idx;
   logic                       w_tick;
   logic                       w_clear;

   // Counter restarts on every state change so each state/bit begins at count 0.
   assign w_clear = (w_next != r_state);

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (w_clear),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      fifo_read_en = 1'b0;
      tx           = 1'b1;
      busy         = (r_state != S_IDLE);
      tx_done      = 1'b0;
      case (r_state)
         S_IDLE:  if (tx_en && !fifo_empty) w_next = S_FETCH;
         S_FETCH: begin
            fifo_read_en = 1'b1;
            w_next       = S_LOAD;
         end
         S_LOAD:  w_next = S_START;
         S_START: begin
            tx = 1'b0;
            if (w_tick) w_next = S_DATA;
         end
         S_DATA: begin
            tx = r_shift[0];
            if (w_tick && (r_bit_idx == LAST_BIT)) w_next = S_STOP;
         end
         S_STOP: begin
            tx_done = w_tick;
            if (w_tick) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift   <= '0;
         r_bit_idx <= '0;
      end else if (r_state == S_LOAD) begin
         r_shift <= fifo_data[FRAME_DATA_BITS-1:0];
      end else if ((r_state == S_DATA) && w_tick) begin
         r_shift   <= r_shift >> 1;
         r_bit_idx <= r_bit_idx + 3'd1;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx with a behavioural 16-deep FIFO and serial frame monitor.
module tb_fifo_uart_tx;

   localparam int CPB    = 16;
   localparam int FRAME  = 10 * CPB;
   localparam int PERIOD = FRAME + 3;

   logic       clk        = 1'b0;
   logic       rst        = 1'b0;
   logic       tx_en      = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data  = '0;
   logic       fifo_read_en;
   logic       tx;
   logic       busy;
   logic       tx_done;

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .DATA_W       (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_en        (tx_en),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .fifo_read_en (fifo_read_en),
      .tx           (tx),
      .busy         (busy),
      .tx_done      (tx_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Behavioural FIFO: registered data_out and empty, pop on read_en, push on write.
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   logic       wr_req  = 1'b0;
   logic [7:0] wr_data = '0;
   int         cyc     = 0;
   int         simul   = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_read_en && wr_req) simul++;
      if (fifo_read_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      if (wr_req && fifo_q.size() < 16) fifo_q.push_back(wr_data);
      fifo_empty <= (fifo_q.size() == 0);
   end

   // Read-side monitor.
   int  reads         = 0;
   int  last_read     = -1;
   bit  check_spacing = 1'b0;
   logic prev_read    = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         if (fifo_read_en) begin
            check("read_nonempty", 32'(fifo_q.size() > 0), 1);
            check("read_single", prev_read, 0);
            if (check_spacing && last_read >= 0) check("read_period", cyc - last_read, PERIOD);
            last_read = cyc;
            reads++;
         end
         prev_read = fifo_read_en;
      end else begin
         prev_read = 1'b0;
      end
   end

   // Serial frame monitor: compares every cycle of the line against the expected frame.
   bit         mon_active = 1'b0;
   int         mon_k      = 0;
   int         mon_err    = 0;
   logic [9:0] mon_frame  = '1;
   int         frames     = 0;

   always @(negedge clk) begin
      if (!rst) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && tx == 1'b0) begin
            mon_active = 1'b1;
            mon_k      = 0;
            mon_err    = 0;
            check("start_latency", cyc - last_read, 2);
            check("frame_expected", 32'(exp_q.size() > 0), 1);
            mon_frame = (exp_q.size() > 0) ? {1'b1, exp_q[0], 1'b0} : 10'h3FF;
         end
         if (mon_active) begin
            if (tx !== mon_frame[mon_k / CPB]) mon_err++;
            if (busy !== 1'b1) mon_err++;
            if (tx_done !== (mon_k == FRAME - 1)) mon_err++;
            if (mon_k == FRAME - 1) begin
               check("frame_bits", mon_err, 0);
               check("done_offset", cyc - last_read, FRAME + 1);
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               frames++;
               mon_active = 1'b0;
            end else begin
               mon_k++;
            end
         end else begin
            check("idle_done", tx_done, 0);
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      wr_req  = 1'b1;
      wr_data = b;
      exp_q.push_back(b);
      @(negedge clk);
      wr_req = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget, input string name);
      int n = 0;
      while (frames < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(frames >= target), 1);
   endtask

   task automatic wait_frame_pos(input int k, input int budget);
      int n = 0;
      while (!(mon_active && mon_k >= k) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("reach_frame_pos", 32'(mon_active && mon_k >= k), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, f0, e, s0;

      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_read_en", fifo_read_en, 0);
      check("reset_tx_done", tx_done, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single byte 0xA5.
      r0 = reads; f0 = frames;
      tx_en = 1'b1;
      push_byte(8'hA5);
      wait_frames(f0 + 1, PERIOD + 20, "single_frame");
      repeat (2) @(negedge clk);
      check("single_reads", reads - r0, 1);
      check("single_empty", fifo_empty, 1);
      check("single_busy_low", busy, 0);

      // Empty FIFO with tx_en held high.
      r0 = reads; e = 0;
      repeat (500) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) e++;
      end
      check("empty_idle_line", e, 0);
      check("empty_no_read", reads - r0, 0);

      // Full FIFO burst of 16 random bytes.
      tx_en = 1'b0;
      for (int i = 0; i < 16; i++) push_byte(8'($urandom));
      @(negedge clk);
      r0 = reads; f0 = frames;
      last_read = -1; check_spacing = 1'b1;
      tx_en = 1'b1;
      wait_frames(f0 + 16, 16 * PERIOD + 50, "burst_frames");
      check_spacing = 1'b0;
      repeat (3) @(negedge clk);
      check("burst_reads", reads - r0, 16);
      check("burst_busy_low", busy, 0);
      check("burst_scoreboard_empty", exp_q.size(), 0);

      // tx_en dropped during data bit 3 of the first of two queued bytes.
      tx_en = 1'b0;
      push_byte(8'($urandom));
      push_byte(8'($urandom));
      r0 = reads; f0 = frames;
      tx_en = 1'b1;
      wait_frame_pos(4 * CPB + 3, PERIOD);
      tx_en = 1'b0;
      wait_frames(f0 + 1, PERIOD, "gate_first_frame");
      repeat (300) @(negedge clk);
      check("gate_held_reads", reads - r0, 1);
      check("gate_held_busy", busy, 0);
      tx_en = 1'b1;
      wait_frames(f0 + 2, PERIOD + 20, "gate_second_frame");
      check("gate_total_reads", reads - r0, 2);

      // Reset during data bit 5: the in-flight byte is lost, the next one still goes out.
      tx_en = 1'b0;
      push_byte(8'($urandom));
      push_byte(8'($urandom));
      r0 = reads; f0 = frames;
      tx_en = 1'b1;
      wait_frame_pos(6 * CPB + 5, PERIOD);
      #2 rst = 1'b0;
      void'(exp_q.pop_front());
      #1;
      check("abort_tx_high", tx, 1);
      check("abort_busy_low", busy, 0);
      check("abort_read_low", fifo_read_en, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_frames(f0 + 1, 2 * PERIOD, "abort_next_frame");
      repeat (3) @(negedge clk);
      check("abort_reads", reads - r0, 2);
      check("abort_scoreboard_empty", exp_q.size(), 0);

      // Write lands on the same edge as the FETCH read with one byte held.
      s0 = simul; f0 = frames;
      push_byte(8'($urandom));
      push_byte(8'($urandom));
      wait_frames(f0 + 2, 2 * PERIOD + 40, "simul_frames");
      check("simul_overlap", simul - s0, 1);
      repeat (3) @(negedge clk);
      check("simul_scoreboard_empty", exp_q.size(), 0);
      check("simul_fifo_empty", fifo_empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
